// File: rtl/dphy_rx_lane.sv
// Receive side of one D-PHY data lane: LP state filtering, HS entry and sync-word alignment,
// HS byte output, and escape-mode LPDT decode (spaced-one-hot, MSB first).
module dphy_rx_lane #(
  parameter int unsigned LP_FILTER    = 4,
  parameter int unsigned SYNC_TIMEOUT = 32,
  parameter logic [7:0]  SYNC_WORD    = 8'hB8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       lines_enable,
  input  logic       LP_p_input,
  input  logic       LP_n_input,
  input  logic [7:0] hs_input,
  input  logic [7:0] hs_settle_val,
  output logic [7:0] data_out,
  output logic       data_valid,
  output logic       hs_active,
  output logic       lp_active,
  output logic       lane_stop,
  output logic       sot_err,
  output logic       esc_err
);

  typedef enum logic [3:0] {
    StDisabled, StStop, StHsRqst, StHsSettle, StHsSync, StHsActive, StHsWait,
    StEscE1, StEscE2, StEscE3, StEscCmd, StLpdt, StEscWait
  } state_e;

  localparam logic [1:0] Lp00      = 2'b00;
  localparam logic [1:0] Lp01      = 2'b01;
  localparam logic [1:0] Lp10      = 2'b10;
  localparam logic [1:0] Lp11      = 2'b11;
  localparam logic [7:0] CmdLpdt   = 8'hE1;
  localparam logic [3:0] FilterLen = 4'(LP_FILTER);
  localparam logic [7:0] SyncLoad  = 8'(SYNC_TIMEOUT);

  state_e     state_q, state_d;
  logic [1:0] lp_raw, lp_cand_q, lp_state_q, lp_state_d;
  logic [3:0] lp_cnt_q, lp_cnt_d;
  logic [7:0] hs_prev_q;
  logic [2:0] offset_q, offset_d;
  logic [7:0] cnt_q, cnt_d;  // settle count, then reused as sync-search timeout
  logic [7:0] shift_q, shift_d;
  logic [2:0] bit_cnt_q, bit_cnt_d;
  logic       mark_vld_q, mark_vld_d, mark_bit_q, mark_bit_d;
  logic [7:0] data_out_q, data_out_d;
  logic       data_valid_q, data_valid_d;
  logic       hs_active_q, hs_active_d, lp_active_q, lp_active_d, lane_stop_q, lane_stop_d;
  logic       sot_err_q, sot_err_d, esc_err_q, esc_err_d;

  logic [15:0] window;
  logic [7:0]  hs_byte, lp_byte, cnt_dec;
  logic        sync_hit;
  logic [2:0]  sync_off;

  always_comb begin
    lp_raw = {LP_p_input, LP_n_input};
    if (lp_raw == lp_cand_q) lp_cnt_d = (lp_cnt_q == 4'hF) ? lp_cnt_q : lp_cnt_q + 4'd1;
    else                     lp_cnt_d = 4'd1;
    lp_state_d = (lp_cnt_d >= FilterLen) ? lp_raw : lp_state_q;
  end

  // Lowest matching offset wins, so scan downward and let later hits overwrite.
  always_comb begin
    window   = {hs_input, hs_prev_q};
    hs_byte  = 8'(window >> offset_q);
    sync_hit = 1'b0;
    sync_off = 3'd0;
    for (int k = 7; k >= 0; k--) begin
      if (window[k +: 8] == SYNC_WORD) begin
        sync_hit = 1'b1;
        sync_off = 3'(k);
      end
    end
  end

  always_comb begin
    state_d      = state_q;
    offset_d     = offset_q;
    cnt_d        = cnt_q;
    shift_d      = shift_q;
    bit_cnt_d    = bit_cnt_q;
    mark_vld_d   = mark_vld_q;
    mark_bit_d   = mark_bit_q;
    data_out_d   = data_out_q;
    data_valid_d = 1'b0;
    sot_err_d    = 1'b0;
    esc_err_d    = 1'b0;
    lp_byte      = {shift_q[6:0], mark_bit_q};
    cnt_dec      = (cnt_q == 8'd0) ? 8'd0 : cnt_q - 8'd1;

    unique case (state_q)
      StDisabled: if (lp_state_q == Lp11) state_d = StStop;
      StStop: begin
        if (lp_state_q == Lp01)      state_d = StHsRqst;
        else if (lp_state_q == Lp10) state_d = StEscE1;
      end
      StHsRqst: begin
        if (lp_state_q == Lp00) begin
          state_d = StHsSettle;
          cnt_d   = (hs_settle_val == 8'd0) ? 8'd1 : hs_settle_val;
        end else if (lp_state_q == Lp11) begin
          state_d = StStop;
        end else if (lp_state_q == Lp10) begin
          state_d   = StStop;
          esc_err_d = 1'b1;
        end
      end
      StHsSettle: begin
        if (lp_state_q == Lp11) begin
          state_d = StStop;
        end else begin
          cnt_d = cnt_dec;
          if (cnt_dec == 8'd0) begin
            state_d = StHsSync;
            cnt_d   = SyncLoad;
          end
        end
      end
      StHsSync: begin
        if (lp_state_q == Lp11) begin
          state_d = StStop;
        end else if (sync_hit) begin
          offset_d = sync_off;
          state_d  = StHsActive;
        end else begin
          cnt_d = cnt_dec;
          if (cnt_dec == 8'd0) begin
            sot_err_d = 1'b1;
            state_d   = StHsWait;
          end
        end
      end
      StHsActive: begin
        // Stop emitting on the edge the filter declares LP-11.
        if (lp_state_q == Lp11) begin
          state_d = StStop;
        end else if (lp_state_d != Lp11) begin
          data_out_d   = hs_byte;
          data_valid_d = 1'b1;
        end
      end
      StHsWait, StEscWait: if (lp_state_q == Lp11) state_d = StStop;
      StEscE1: begin
        if (lp_state_q == Lp00) state_d = StEscE2;
        else if (lp_state_q != Lp10) begin
          state_d   = StStop;
          esc_err_d = 1'b1;
        end
      end
      StEscE2: begin
        if (lp_state_q == Lp01) state_d = StEscE3;
        else if (lp_state_q != Lp00) begin
          state_d   = StStop;
          esc_err_d = 1'b1;
        end
      end
      StEscE3: begin
        if (lp_state_q == Lp00) begin
          state_d    = StEscCmd;
          mark_vld_d = 1'b0;
          bit_cnt_d  = 3'd0;
          shift_d    = 8'd0;
        end else if (lp_state_q != Lp01) begin
          state_d   = StStop;
          esc_err_d = 1'b1;
        end
      end
      StEscCmd, StLpdt: begin
        unique case (lp_state_q)
          Lp10, Lp01: begin
            mark_vld_d = 1'b1;
            mark_bit_d = (lp_state_q == Lp10);
          end
          Lp00: begin
            if (mark_vld_q) begin
              mark_vld_d = 1'b0;
              shift_d    = lp_byte;
              bit_cnt_d  = bit_cnt_q + 3'd1;
              if (bit_cnt_q == 3'd7) begin
                if (state_q == StLpdt) begin
                  data_out_d   = lp_byte;
                  data_valid_d = 1'b1;
                end else if (lp_byte == CmdLpdt) begin
                  state_d = StLpdt;
                end else begin
                  esc_err_d = 1'b1;
                  state_d   = StEscWait;
                end
              end
            end
          end
          default: begin
            state_d    = StStop;
            mark_vld_d = 1'b0;
            if (!(state_q == StLpdt && mark_vld_q && mark_bit_q && bit_cnt_q == 3'd0)) begin
              esc_err_d = 1'b1;
            end
          end
        endcase
      end
      default: state_d = StDisabled;
    endcase

    if (!lines_enable) begin
      state_d      = StDisabled;
      data_valid_d = 1'b0;
      sot_err_d    = 1'b0;
      esc_err_d    = 1'b0;
    end

    hs_active_d = (state_d == StHsActive);
    lp_active_d = (state_d == StLpdt);
    lane_stop_d = (state_d == StStop);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= StDisabled;
      lp_cand_q    <= 2'b00;
      lp_cnt_q     <= 4'd0;
      lp_state_q   <= 2'b00;
      hs_prev_q    <= 8'd0;
      offset_q     <= 3'd0;
      cnt_q        <= 8'd0;
      shift_q      <= 8'd0;
      bit_cnt_q    <= 3'd0;
      mark_vld_q   <= 1'b0;
      mark_bit_q   <= 1'b0;
      data_out_q   <= 8'd0;
      data_valid_q <= 1'b0;
      hs_active_q  <= 1'b0;
      lp_active_q  <= 1'b0;
      lane_stop_q  <= 1'b0;
      sot_err_q    <= 1'b0;
      esc_err_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      lp_cand_q    <= lp_raw;
      lp_cnt_q     <= lp_cnt_d;
      lp_state_q   <= lp_state_d;
      hs_prev_q    <= hs_input;
      offset_q     <= offset_d;
      cnt_q        <= cnt_d;
      shift_q      <= shift_d;
      bit_cnt_q    <= bit_cnt_d;
      mark_vld_q   <= mark_vld_d;
      mark_bit_q   <= mark_bit_d;
      data_out_q   <= data_out_d;
      data_valid_q <= data_valid_d;
      hs_active_q  <= hs_active_d;
      lp_active_q  <= lp_active_d;
      lane_stop_q  <= lane_stop_d;
      sot_err_q    <= sot_err_d;
      esc_err_q    <= esc_err_d;
    end
  end

  assign data_out   = data_out_q;
  assign data_valid = data_valid_q;
  assign hs_active  = hs_active_q;
  assign lp_active  = lp_active_q;
  assign lane_stop  = lane_stop_q;
  assign sot_err    = sot_err_q;
  assign esc_err    = esc_err_q;

endmodule

// File: tb/tb_dphy_rx_lane.sv
// Bench for dphy_rx_lane: directed LP/HS/escape sequences; HS payloads come from a serial
// bit-stream model and LPDT payloads from a byte list, both randomized.
`timescale 1ns/1ps
module tb_dphy_rx_lane;
  localparam int unsigned FILT = 4;
  localparam int unsigned TMO  = 32;
  localparam logic [7:0]  SYNC = 8'hB8;
  localparam int          LEAD = 10;
  localparam int          HOLD = 6;

  logic       clk = 1'b0;
  logic       rst, lines_enable, lp_p, lp_n;
  logic [7:0] hs_input, hs_settle_val;
  logic [7:0] data_out;
  logic       data_valid, hs_active, lp_active, lane_stop, sot_err, esc_err;

  always #5 clk = ~clk;

  dphy_rx_lane #(.LP_FILTER(FILT), .SYNC_TIMEOUT(TMO), .SYNC_WORD(SYNC)) dut (
    .clk          (clk),
    .rst          (rst),
    .lines_enable (lines_enable),
    .LP_p_input   (lp_p),
    .LP_n_input   (lp_n),
    .hs_input     (hs_input),
    .hs_settle_val(hs_settle_val),
    .data_out     (data_out),
    .data_valid   (data_valid),
    .hs_active    (hs_active),
    .lp_active    (lp_active),
    .lane_stop    (lane_stop),
    .sot_err      (sot_err),
    .esc_err      (esc_err)
  );

  int          checks = 0;
  int          errors = 0;
  int          sot_cnt, esc_cnt, hs_idx;
  logic        hs_on = 1'b0;
  logic [7:0]  got_q[$];
  logic [511:0] stream;

  initial begin
    #2ms;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // One clock; outputs sampled 1ns after the edge, HS word for the next cycle applied.
  task automatic step();
    @(posedge clk);
    #1;
    if (data_valid) got_q.push_back(data_out);
    if (sot_err) sot_cnt++;
    if (esc_err) esc_cnt++;
    if (hs_on) begin
      hs_idx++;
      hs_input = stream[8*hs_idx +: 8];
    end
  endtask

  task automatic lp(input logic [1:0] v, input int n);
    {lp_p, lp_n} = v;
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic clear_obs();
    got_q.delete();
    sot_cnt = 0;
    esc_cnt = 0;
  endtask

  task automatic esc_entry();
    lp(2'b10, HOLD); lp(2'b00, HOLD); lp(2'b01, HOLD); lp(2'b00, HOLD);
  endtask

  task automatic esc_byte(input logic [7:0] b);
    for (int i = 7; i >= 0; i--) begin
      lp(b[i] ? 2'b10 : 2'b01, HOLD);
      lp(2'b00, HOLD);
    end
  endtask

  // Serial model: sync starts at bit z; byte j follows at bit z+8+8j. Sync is first
  // fully visible in word z/8+1; each later cycle yields one byte until LP-11 has been
  // sampled FILT times (first LP-11 cycle is word t).
  task automatic hs_burst(input int off, input logic fixed, input int npay);
    int z, det, t, nexp;
    z = 8*LEAD + off;
    for (int w = 0; w < 16; w++) stream[32*w +: 32] = $urandom;
    for (int i = 0; i < z; i++) stream[i] = 1'b0;
    stream[z +: 8] = SYNC;
    if (fixed) begin
      stream[z+8  +: 8] = 8'h11;
      stream[z+16 +: 8] = 8'h22;
    end
    det  = z/8 + 1;
    t    = det + 1 + npay;
    nexp = t + FILT - 2 - det;
    clear_obs();
    lp(2'b11, 8);
    lp(2'b01, 8);
    hs_idx   = 0;
    hs_input = stream[7:0];
    hs_on    = 1'b1;
    {lp_p, lp_n} = 2'b00;
    for (int c = 0; c < t; c++) begin
      step();
      if (c == det - 1) chk("hs_active_before_sync", hs_active, 1'b0);
      if (c == t - 1)   chk("hs_active_locked", hs_active, 1'b1);
    end
    lp(2'b11, 8);
    hs_on    = 1'b0;
    hs_input = 8'h00;
    chk("hs_byte_count", got_q.size(), nexp);
    for (int j = 0; j < nexp && j < got_q.size(); j++) chk("hs_byte", got_q[j], stream[z+8+8*j +: 8]);
    if (fixed) begin
      chk("hs_first_11", got_q.size() > 0 ? got_q[0] : 8'hxx, 8'h11);
      chk("hs_second_22", got_q.size() > 1 ? got_q[1] : 8'hxx, 8'h22);
    end
    chk("hs_exit_stop", lane_stop, 1'b1);
    chk("hs_exit_inactive", hs_active, 1'b0);
    chk("hs_no_err", sot_cnt + esc_cnt, 0);
  endtask

  // HsRqst sees 00 in cycle FILT, settles max(s,1) cycles, then searches TMO cycles.
  task automatic hs_timeout(input logic [7:0] settle);
    int s, exp_c, seen_c;
    s             = (settle == 8'd0) ? 1 : int'(settle);
    exp_c         = FILT + 1 + s + TMO - 1;
    seen_c        = -1;
    hs_settle_val = settle;
    clear_obs();
    lp(2'b11, 8);
    lp(2'b01, 8);
    {lp_p, lp_n} = 2'b00;
    for (int c = 0; c < exp_c + 10; c++) begin
      step();
      if (sot_err && seen_c < 0) seen_c = c;
    end
    chk("sot_cycle", seen_c, exp_c);
    chk("sot_single", sot_cnt, 1);
    chk("sot_no_data", got_q.size(), 0);
    chk("sot_not_active", hs_active, 1'b0);
    lp(2'b11, 8);
    chk("sot_stop", lane_stop, 1'b1);
  endtask

  task automatic lpdt(input logic fixed, input int n);
    logic [7:0] bq[$];
    if (fixed) bq.push_back(8'hA5);
    else for (int i = 0; i < n; i++) bq.push_back(8'($urandom));
    clear_obs();
    esc_entry();
    esc_byte(8'hE1);
    chk("lpdt_active", lp_active, 1'b1);
    foreach (bq[i]) esc_byte(bq[i]);
    lp(2'b10, HOLD);
    lp(2'b11, HOLD + 2);
    chk("lpdt_count", got_q.size(), bq.size());
    for (int i = 0; i < bq.size() && i < got_q.size(); i++) chk("lpdt_byte", got_q[i], bq[i]);
    chk("lpdt_no_err", esc_cnt, 0);
    chk("lpdt_stop", lane_stop, 1'b1);
    chk("lpdt_inactive", lp_active, 1'b0);
  endtask

  initial begin
    rst = 1'b1; lines_enable = 1'b1; lp_p = 1'b1; lp_n = 1'b1;
    hs_input = 8'h00; hs_settle_val = 8'd3;
    clear_obs();
    for (int i = 0; i < 3; i++) step();
    chk("rst_outputs", {data_out, data_valid, hs_active, lp_active, lane_stop, sot_err, esc_err}, 0);
    rst = 1'b0;
    lp(2'b11, 8);
    chk("reset_to_stop", lane_stop, 1'b1);

    hs_burst(3, 1'b1, 6);
    hs_timeout(8'd3);
    hs_timeout(8'd0);
    lpdt(1'b1, 1);

    // Unknown escape command
    clear_obs();
    esc_entry();
    esc_byte(8'h1E);
    chk("badcmd_err", esc_cnt, 1);
    chk("badcmd_no_lpdt", lp_active, 1'b0);
    esc_byte(8'($urandom));
    lp(2'b11, 8);
    chk("badcmd_stop", lane_stop, 1'b1);
    chk("badcmd_err_once", esc_cnt, 1);
    chk("badcmd_no_data", got_q.size(), 0);

    // Short 01 glitch must not start HS entry
    lp(2'b01, FILT - 1);
    chk("glitch_stop", lane_stop, 1'b1);
    lp(2'b00, 10);
    chk("glitch_still_stop", lane_stop, 1'b1);
    chk("glitch_no_hs", hs_active, 1'b0);
    lp(2'b11, 4);

    // Reset mid-LPDT after 4 bits
    clear_obs();
    esc_entry();
    esc_byte(8'hE1);
    esc_byte(8'h5A);
    for (int i = 7; i >= 4; i--) begin
      lp(i[0] ? 2'b01 : 2'b10, HOLD);
      lp(2'b00, HOLD);
    end
    chk("midrst_lpdt", lp_active, 1'b1);
    rst = 1'b1;
    step();
    chk("midrst_outputs", {data_out, data_valid, hs_active, lp_active, lane_stop, sot_err, esc_err}, 0);
    rst = 1'b0;
    lp(2'b11, 8);
    chk("midrst_stop", lane_stop, 1'b1);
    chk("midrst_bytes", got_q.size(), 1);
    chk("midrst_no_err", esc_cnt, 0);

    // lines_enable drop and recovery
    lines_enable = 1'b0;
    step();
    chk("disable_stop_low", lane_stop, 1'b0);
    lines_enable = 1'b1;
    step();
    chk("enable_stop", lane_stop, 1'b1);

    for (int r = 0; r < 4; r++) begin
      hs_settle_val = 8'($urandom_range(0, 5));
      hs_burst(int'($urandom_range(0, 7)), 1'b0, int'($urandom_range(2, 8)));
      lpdt(1'b0, int'($urandom_range(1, 4)));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
